// File: rtl/sign_ext.sv
// sign_ext: registered immediate extractor and sign-extender for the LEGv8
// datapath. Decodes a 32-bit instruction word, picks the immediate field of
// the recognised format and sign-extends it to 64 bits; anything else is zero.
//
// Ports:
//   clk    in   1   system clock
//   reset  in   1   synchronous, active-high reset
//   a      in  32   instruction word
//   y      out 64   sign-extended immediate (registered, 1-cycle latency)
//   kind   out  2   format tag: 00 none, 01 D-type, 10 CB-type, 11 B-type
//
// Configuration macro: SIGNEXT_BRANCH_EN
//   defined   -> B (kind 11) and CBNZ (kind 10) are also decoded
//   undefined -> those opcodes give y = 0, kind = 00
module sign_ext (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   output logic [63:0] y,
   output logic [1:0]  kind
);

   localparam int unsigned IW = 32;
   localparam int unsigned YW = 64;
   localparam int unsigned KW = 2;

   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;
`ifdef SIGNEXT_BRANCH_EN
   localparam logic [7:0]  OP_CBNZ = 8'b10110101;
   localparam logic [5:0]  OP_B    = 6'b000101;
`endif

   localparam logic [KW-1:0] KIND_NONE = 2'b00;
   localparam logic [KW-1:0] KIND_D    = 2'b01;
   localparam logic [KW-1:0] KIND_CB   = 2'b10;
`ifdef SIGNEXT_BRANCH_EN
   localparam logic [KW-1:0] KIND_B    = 2'b11;
`endif

   logic [YW-1:0] y_c;
   logic [KW-1:0] kind_c;

   // Register bits only B consumes; keeps the default build free of unused-input noise.
   logic unused_low_bits;
   assign unused_low_bits = ^a[4:0];

   // Decode and sign-extend; D checked first, then CB, then B (encodings are disjoint).
   always_comb begin
      y_c    = '0;
      kind_c = KIND_NONE;
      if (a[IW-1:21] == OP_LDUR || a[IW-1:21] == OP_STUR) begin
         y_c    = {{(YW-9){a[20]}}, a[20:12]};
         kind_c = KIND_D;
      end else if (a[IW-1:24] == OP_CBZ) begin
         y_c    = {{(YW-19){a[23]}}, a[23:5]};
         kind_c = KIND_CB;
      end
`ifdef SIGNEXT_BRANCH_EN
      else if (a[IW-1:24] == OP_CBNZ) begin
         y_c    = {{(YW-19){a[23]}}, a[23:5]};
         kind_c = KIND_CB;
      end else if (a[IW-1:26] == OP_B) begin
         y_c    = {{(YW-26){a[25]}}, a[25:0]};
         kind_c = KIND_B;
      end
`endif
   end

   // Output register; reset discards whatever was in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         y    <= '0;
         kind <= KIND_NONE;
      end else begin
         y    <= y_c;
         kind <= kind_c;
      end
   end

endmodule

// File: tb/tb_sign_ext.sv
// tb_sign_ext: directed-vector bench for sign_ext with hand-computed results.
module tb_sign_ext;

   logic        clk;
   logic        reset;
   logic [31:0] a;
   logic [63:0] y;
   logic [1:0]  kind;

   int n_vec;
   int n_err;

   sign_ext dut (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .y     (y),
      .kind  (kind)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive on the falling edge, clock it in, then check just after the rising edge.
   task automatic step(input logic r, input logic [31:0] word,
                       input logic [63:0] exp_y, input logic [1:0] exp_kind,
                       input string tag);
      @(negedge clk);
      reset = r;
      a     = word;
      @(posedge clk);
      #1;
      n_vec++;
      assert (y === exp_y)
      else begin
         n_err++;
         $error("FAIL %s y observed=%h expected=%h", tag, y, exp_y);
      end
      n_vec++;
      assert (kind === exp_kind)
      else begin
         n_err++;
         $error("FAIL %s kind observed=%b expected=%b", tag, kind, exp_kind);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      a     = 32'h0;

      // Reset held two edges with a live LDUR on the input.
      step(1'b1, 32'hF85083E0, 64'h0, 2'b00, "rst_edge1");
      step(1'b1, 32'hF85083E0, 64'h0, 2'b00, "rst_edge2");
      step(1'b0, 32'hF85083E0, 64'hFFFFFFFFFFFFFF08, 2'b01, "rst_release");

      // D-type
      step(1'b0, 32'hF84003E0, 64'h0,                2'b01, "ldur_zero");
      step(1'b0, 32'hF85083E0, 64'hFFFFFFFFFFFFFF08, 2'b01, "ldur_neg");
      step(1'b0, 32'hF81F03E0, 64'hFFFFFFFFFFFFFFF0, 2'b01, "stur_neg");
      step(1'b0, 32'hF800F3E0, 64'h000000000000000F, 2'b01, "stur_pos");

      // Non-matching opcodes
      step(1'b0, 32'hB80043E0, 64'h0, 2'b00, "sturw");
      step(1'b0, 32'hB800C3E0, 64'h0, 2'b00, "sturw2");
      step(1'b0, 32'hD2800020, 64'h0, 2'b00, "movz");
      step(1'b0, 32'h8B020020, 64'h0, 2'b00, "add_r");
      step(1'b0, 32'h91000421, 64'h0, 2'b00, "addi");

      // CBZ
      step(1'b0, 32'hB4000041, 64'h2,                2'b10, "cbz_pos");
      step(1'b0, 32'hB4FFFFE0, 64'hFFFFFFFFFFFFFFFF, 2'b10, "cbz_neg1");
      step(1'b0, 32'hB47FFFE0, 64'h000000000003FFFF, 2'b10, "cbz_maxpos");
      step(1'b0, 32'hB4800000, 64'hFFFFFFFFFFFC0000, 2'b10, "cbz_minneg");

      // Back-to-back: format changes every cycle, no bubbles
      step(1'b0, 32'hF85083E0, 64'hFFFFFFFFFFFFFF08, 2'b01, "b2b_ldur");
      step(1'b0, 32'hB4000041, 64'h2,                2'b10, "b2b_cbz");
      step(1'b0, 32'hD2800020, 64'h0,                2'b00, "b2b_movz");
      step(1'b0, 32'hF81F03E0, 64'hFFFFFFFFFFFFFFF0, 2'b01, "b2b_stur");
      step(1'b0, 32'hB4FFFFE0, 64'hFFFFFFFFFFFFFFFF, 2'b10, "b2b_cbz2");

      // Reset mid-stream drops the in-flight word, then recovers next edge
      step(1'b1, 32'hF81F03E0, 64'h0,                2'b00, "mid_rst");
      step(1'b0, 32'hB4000041, 64'h2,                2'b10, "post_rst");

      // Branch formats depend on the build
`ifdef SIGNEXT_BRANCH_EN
      step(1'b0, 32'h17FFFFFF, 64'hFFFFFFFFFFFFFFFF, 2'b11, "b_neg1");
      step(1'b0, 32'h14000010, 64'h10,               2'b11, "b_pos");
      step(1'b0, 32'hB5000041, 64'h2,                2'b10, "cbnz");
`else
      step(1'b0, 32'h17FFFFFF, 64'h0, 2'b00, "b_off");
      step(1'b0, 32'h14000010, 64'h0, 2'b00, "b_off2");
      step(1'b0, 32'hB5000041, 64'h0, 2'b00, "cbnz_off");
`endif

      // Output holds between edges
      @(negedge clk);
      n_vec++;
`ifdef SIGNEXT_BRANCH_EN
      assert (y === 64'h2)
      else begin
         n_err++;
         $error("FAIL hold y observed=%h expected=%h", y, 64'h2);
      end
`else
      assert (y === 64'h0)
      else begin
         n_err++;
         $error("FAIL hold y observed=%h expected=%h", y, 64'h0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
